// File: rtl/mb_rx_deserializer.sv
// mb_rx_deserializer: rebuilds LSB-first serial words into a one-entry valid/ready output register.
// Optional MB_RX_DESER_WORD_CNT_EN adds WORD_CNT, a 16-bit count of words loaded into P_DATA.
module mb_rx_deserializer #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SER_IN,
  input  logic                  DESER_EN,
  input  logic                  P_READY,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  P_VALID,
  output logic                  OVERRUN,
  output logic                  ABORT
`ifdef MB_RX_DESER_WORD_CNT_EN
  ,
  output logic [15:0]           WORD_CNT
`endif
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [DATA_WIDTH-2:0] shift;
  logic last, done, load;
  assign last = &counter;
  assign done = DESER_EN && last;
  assign load = done && (!P_VALID || P_READY);
  // The final bit goes straight into P_DATA, so the shift register never holds it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      counter <= '0;
      shift   <= '0;
      P_DATA  <= '0;
      P_VALID <= 1'b0;
      OVERRUN <= 1'b0;
      ABORT   <= 1'b0;
`ifdef MB_RX_DESER_WORD_CNT_EN
      WORD_CNT <= '0;
`endif
    end else begin
      OVERRUN <= done && P_VALID && !P_READY;
      ABORT   <= !DESER_EN && state == SHIFT && counter != '0;
      if (DESER_EN) begin
        state   <= SHIFT;
        counter <= counter + COUNTER_WIDTH'(1);
        if (!last) shift[counter] <= SER_IN;
      end else begin
        state   <= IDLE;
        counter <= '0;
      end
      if (load) P_DATA <= {SER_IN, shift};
      P_VALID <= load || (P_VALID && !P_READY);
`ifdef MB_RX_DESER_WORD_CNT_EN
      WORD_CNT <= WORD_CNT + 16'(load);
`endif
    end
  end
endmodule

// File: tb/tb_mb_rx_deserializer.sv
// tb_mb_rx_deserializer: randomized scoreboard bench with a bit-queue reference model.
module tb_mb_rx_deserializer;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, ser = 1'b0, en = 1'b0, rdy = 1'b0;
  logic [W-1:0] p_data;
  logic p_valid, ovr, abt;
`ifdef MB_RX_DESER_WORD_CNT_EN
  logic [15:0] word_cnt;
`endif
  int pass_cnt = 0, chk_cnt = 0;
  logic [W-1:0] exp_q[$];
  bit bits[$];
  bit m_full = 0, m_ovr = 0, m_abt = 0, m_fin;
  int m_loads = 0;
  logic [W-1:0] m_word;

  always #5 clk = ~clk;

  mb_rx_deserializer #(.DATA_WIDTH(W), .COUNTER_WIDTH(5)) dut (
    .CLK(clk), .RST(rst), .SER_IN(ser), .DESER_EN(en), .P_READY(rdy),
    .P_DATA(p_data), .P_VALID(p_valid), .OVERRUN(ovr), .ABORT(abt)
`ifdef MB_RX_DESER_WORD_CNT_EN
    , .WORD_CNT(word_cnt)
`endif
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: collect bits in a queue, a full queue is a word; buffer is one flag.
  initial forever begin
    @(posedge clk);
    m_ovr = 0;
    m_abt = 0;
    m_fin = 0;
    if (rst) begin
      bits.delete();
      exp_q.delete();
      m_full = 0;
      m_loads = 0;
    end else begin
      if (en) begin
        bits.push_back(ser);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) m_word[i] = bits[i];
          bits.delete();
          m_fin = 1;
        end
      end else if (bits.size() != 0) begin
        m_abt = 1;
        bits.delete();
      end
      if (m_fin && m_full && !rdy) m_ovr = 1;
      else if (m_fin) begin
        exp_q.push_back(m_word);
        m_full = 1;
        m_loads++;
      end else if (m_full && rdy) m_full = 0;
    end
  end

  // Monitor: compare flags every cycle, pop a word whenever the DUT hands one over.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("p_valid", p_valid, m_full);
      check("overrun", ovr, m_ovr);
      check("abort", abt, m_abt);
      if (p_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_word: got %0h expected none", p_data);
        end else check("p_data", p_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive(bit e, bit b, bit r);
    en = e;
    ser = b;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 ready only on the last bit, 3 random
  task automatic send_word(logic [W-1:0] w, int rmode);
    for (int i = 0; i < W; i++)
      drive(1'b1, w[i], rmode == 3 ? 1'($urandom) : rmode == 2 ? (i == W - 1) : rmode[0]);
  endtask

  task automatic idle(int n, bit r);
    repeat (n) drive(1'b0, 1'b0, r);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_p_data"}, p_data, 0);
    check({tag, "_p_valid"}, p_valid, 0);
    check({tag, "_overrun"}, ovr, 0);
    check({tag, "_abort"}, abt, 0);
`ifdef MB_RX_DESER_WORD_CNT_EN
    check({tag, "_word_cnt"}, word_cnt, 0);
`endif
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(32'hA5C3_0F81, 1);
    idle(2, 1);
    send_word(32'h0000_0001, 1);
    send_word(32'h8000_0000, 1);
    idle(2, 1);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    idle(2, 0);
    send_word(32'h3333_3333, 2);
    idle(1, 0);
    idle(2, 1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom), 1'b1);
    idle(1, 1);
    send_word(32'hDEAD_BEEF, 1);
    idle(3, 1);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, W - 1)) drive(1'b1, 1'($urandom), 1'($urandom));
        idle(1, 1'($urandom));
      end
      send_word($urandom, 3);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'($urandom));
    end
    idle(3, 1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom), 1'b0);
    #2;
    rst = 1'b1;
    en = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1);
    send_word($urandom, 0);
    send_word($urandom, 0);
    send_word($urandom, 2);
    send_word($urandom, 1);
    idle(3, 1);
`ifdef MB_RX_DESER_WORD_CNT_EN
    check("word_cnt", word_cnt, 16'(m_loads));
    check("word_cnt_three", word_cnt, 3);
`endif
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
